data_mem_responder: RTL and testbench

- Data-memory responder for the multi-cycle RV32I core; the slave end of the control unit's data-bus port (`busWe`, `strb` = funct3, ALU address, rs2 write data).
- Stores apply byte/half/word lane masking in a single write cycle (S_MEM).
- Loads are read synchronously; the sign/zero-extended result is registered so it is valid in L_WB.
- Store alignment and range faults are reported through sticky error registers.

---
 rtl/data_mem_responder_pkg.sv | 26 ++
 rtl/data_mem_responder_if.sv | 39 +++
 rtl/data_mem_responder_load_extender.sv | 38 +++
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 tb/tb_data_mem_responder.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_pkg
//  Description : Shared RV32I data-bus definitions. Provides the funct3 codes
//                for loads and stores, which also serve as the bus size
//                strobe (strb).
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    typedef logic [2:0] funct3_t;

    // Load funct3 codes
    localparam funct3_t c_F3_LB  = 3'b000;
    localparam funct3_t c_F3_LH  = 3'b001;
    localparam funct3_t c_F3_LW  = 3'b010;
    localparam funct3_t c_F3_LBU = 3'b100;
    localparam funct3_t c_F3_LHU = 3'b101;

    // Store funct3 codes
    localparam funct3_t c_F3_SB  = 3'b000;
    localparam funct3_t c_F3_SH  = 3'b001;
    localparam funct3_t c_F3_SW  = 3'b010;

endpackage : data_mem_responder_pkg
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_if
//  Description : Data-bus port between the control unit (master) and the
//                data memory (slave).
//                  busAddr  : byte address (ALU result)
//                  busWData : store data, rs2 in the low bits
//                  busWe    : store strobe, one cycle per store
//                  strb     : funct3 size/sign code
//                  busRData : registered, extended load data
//                  busErr   : sticky store-fault flag
//                  errAddr  : address of the first fault since reset/clear
//                  errClr   : synchronous clear of busErr/errAddr
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic        busWe;
    funct3_t     strb;
    logic [31:0] busRData;
    logic        busErr;
    logic [31:0] errAddr;
    logic        errClr;

    modport master (
        output busAddr, busWData, busWe, strb, errClr,
        input  busRData, busErr, errAddr
    );

    modport slave (
        input  busAddr, busWData, busWe, strb, errClr,
        output busRData, busErr, errAddr
    );

endinterface : data_mem_responder_if
`default_nettype wire

// File: rtl/data_mem_responder_load_extender.sv
`default_nettype none
// ============================================================================
//  Module      : load_extender
//  Description : Combinational load lane select and sign/zero extension.
//                  i_word   : 32-bit word read from memory
//                  i_lane   : byte offset within the word
//                  i_funct3 : load funct3 code
//                  o_data   : extended result
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extender
    import data_mem_responder_pkg::*;
(
    input  wire logic [31:0] i_word,
    input  wire logic [1:0]  i_lane,
    input  wire funct3_t     i_funct3,
    output logic [31:0]      o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_lane, 3'b000} +: 8];
        // Halves are chosen by lane[1] alone, so a misaligned half read
        // returns the half containing the addressed byte.
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            c_F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LBU: o_data = {24'h000000, w_byte};
            c_F3_LH:  o_data = {{16{w_half[15]}}, w_half};
            c_F3_LHU: o_data = {16'h0000, w_half};
            default:  o_data = i_word;
        endcase
    end

endmodule : load_extender
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Data memory for the multi-cycle RV32I core. Byte/half/word
//                stores in one cycle, registered extended loads (one cycle
//                latency, read-first), sticky fault reporting for misaligned,
//                out-of-range and bad-strb stores.
//                  clk   : system clock
//                  reset : asynchronous active-high reset
//                  bus   : data bus, slave modport
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter string       INIT_FILE   = ""
) (
    input  wire logic          clk,
    input  wire logic          reset,
    data_mem_responder_if.slave bus
);

    localparam int          c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_DEPTH = 32'(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    // Memory contents are never touched by reset.
    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = 32'h0;
    end

    logic [31:0]        w_off;
    logic [31:0]        w_word_idx;
    logic [1:0]         w_lane;
    logic               w_in_range;
    logic [c_IDX_W-1:0] w_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic               w_misalign;
    logic               w_bad_strb;
    logic               w_fault;
    logic               w_wr_en;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_ext;

    logic [31:0] rdata_d, rdata_q;
    logic        err_d, err_q;
    logic [31:0] err_addr_d, err_addr_q;

    // Address decode
    always_comb begin
        w_off      = bus.busAddr - BASE_ADDR;
        w_word_idx = {2'b00, w_off[31:2]};
        w_lane     = w_off[1:0];
        w_in_range = (bus.busAddr >= BASE_ADDR) && (w_word_idx < c_DEPTH);
        // Out-of-range accesses are steered to word 0 so the array index
        // stays legal; their read result and write are discarded anyway.
        w_idx      = w_in_range ? w_word_idx[c_IDX_W-1:0] : '0;
    end

    // Byte-enable and lane-replicated write data
    always_comb begin
        w_be       = 4'b0000;
        w_wdata    = bus.busWData;
        w_misalign = 1'b0;
        w_bad_strb = 1'b0;
        case (bus.strb)
            c_F3_SB: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{bus.busWData[7:0]}};
            end
            c_F3_SH: begin
                w_be       = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{bus.busWData[15:0]}};
                w_misalign = w_lane[0];
            end
            c_F3_SW: begin
                w_be       = 4'b1111;
                w_misalign = (w_lane != 2'b00);
            end
            default: w_bad_strb = 1'b1;
        endcase
        w_fault = bus.busWe && (!w_in_range || w_misalign || w_bad_strb);
        w_wr_en = bus.busWe && !w_fault;
    end

    // Write port. Gated by reset so a store coincident with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    // Asynchronous array read, registered below: read-first by construction.
    assign w_rd_word = mem[w_idx];

    load_extender u_load_extender (
        .i_word   (w_rd_word),
        .i_lane   (w_lane),
        .i_funct3 (bus.strb),
        .o_data   (w_ext)
    );

    always_comb begin
        rdata_d = w_in_range ? w_ext : 32'h0;

        // A fault in the clear cycle wins and recaptures the address.
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (bus.errClr) begin
            err_d      = 1'b0;
            err_addr_d = 32'h0;
        end
        if (w_fault) begin
            err_d = 1'b1;
            if (!err_q || bus.errClr) err_addr_d = bus.busAddr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus.busRData = rdata_q;
    assign bus.busErr   = err_q;
    assign bus.errAddr  = err_addr_q;

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Directed self-checking bench for data_mem_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int          c_DEPTH = 256;
    localparam logic [31:0] c_BASE  = 32'h1000_0000;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS (c_DEPTH),
        .BASE_ADDR   (c_BASE),
        .INIT_FILE   ("")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- stimulus
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] f3);
        bus.busAddr  = addr;
        bus.busWData = data;
        bus.strb     = f3;
        bus.busWe    = 1'b1;
        @(posedge clk);
        #1;
        bus.busWe    = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                           output logic [31:0] data);
        bus.busAddr = addr;
        bus.strb    = f3;
        bus.busWe   = 1'b0;
        @(posedge clk);
        #1;
        data = bus.busRData;
    endtask

    task automatic pulse_clr();
        bus.errClr = 1'b1;
        @(posedge clk);
        #1;
        bus.errClr = 1'b0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        reset        = 1'b1;
        bus.busAddr  = 32'h0;
        bus.busWData = 32'h0;
        bus.busWe    = 1'b0;
        bus.strb     = 3'b000;
        bus.errClr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.busRData !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want %h", bus.busRData, 32'h0);
        end
        n_cmp++;
        if (bus.busErr !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", bus.busErr);
        end
        n_cmp++;
        if (bus.errAddr !== 32'h0) begin
            n_fail++; $display("FAIL reset_erraddr: got %h want %h", bus.errAddr, 32'h0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word();
        logic [31:0] d;
        do_store(c_BASE + 32'h10, 32'hDEADBEEF, c_F3_SW);
        do_load(c_BASE + 32'h10, c_F3_LW, d);
        n_cmp++;
        if (d !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL word_lw: got %h want %h", d, 32'hDEADBEEF);
        end
    endtask

    task automatic test_byte();
        logic [31:0] d;
        do_store(c_BASE + 32'h10, 32'h11223344, c_F3_SW);
        do_store(c_BASE + 32'h13, 32'h00000080, c_F3_SB);
        do_load(c_BASE + 32'h13, c_F3_LB, d);
        n_cmp++;
        if (d !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL byte_lb: got %h want %h", d, 32'hFFFFFF80);
        end
        do_load(c_BASE + 32'h13, c_F3_LBU, d);
        n_cmp++;
        if (d !== 32'h00000080) begin
            n_fail++; $display("FAIL byte_lbu: got %h want %h", d, 32'h00000080);
        end
        do_load(c_BASE + 32'h10, c_F3_LW, d);
        n_cmp++;
        if (d !== 32'h80223344) begin
            n_fail++; $display("FAIL byte_lw: got %h want %h", d, 32'h80223344);
        end
        do_load(c_BASE + 32'h11, c_F3_LB, d);
        n_cmp++;
        if (d !== 32'h00000033) begin
            n_fail++; $display("FAIL byte_lb_lane1: got %h want %h", d, 32'h00000033);
        end
    endtask

    task automatic test_half();
        logic [31:0] d;
        do_store(c_BASE + 32'h20, 32'h12345678, c_F3_SW);
        do_store(c_BASE + 32'h22, 32'h0000BEEF, c_F3_SH);
        do_load(c_BASE + 32'h22, c_F3_LH, d);
        n_cmp++;
        if (d !== 32'hFFFFBEEF) begin
            n_fail++; $display("FAIL half_lh: got %h want %h", d, 32'hFFFFBEEF);
        end
        do_load(c_BASE + 32'h22, c_F3_LHU, d);
        n_cmp++;
        if (d !== 32'h0000BEEF) begin
            n_fail++; $display("FAIL half_lhu: got %h want %h", d, 32'h0000BEEF);
        end
        do_load(c_BASE + 32'h20, c_F3_LW, d);
        n_cmp++;
        if (d !== 32'hBEEF5678) begin
            n_fail++; $display("FAIL half_lw: got %h want %h", d, 32'hBEEF5678);
        end
        do_load(c_BASE + 32'h20, c_F3_LH, d);
        n_cmp++;
        if (d !== 32'h00005678) begin
            n_fail++; $display("FAIL half_lh_low: got %h want %h", d, 32'h00005678);
        end
        n_cmp++;
        if (bus.busErr !== 1'b0) begin
            n_fail++; $display("FAIL half_noerr: got %b want 0", bus.busErr);
        end
    endtask

    task automatic test_faults();
        logic [31:0] d;
        do_store(c_BASE + 32'h04, 32'hAAAA5555, c_F3_SW);
        do_store(c_BASE + 32'h08, 32'h00000000, c_F3_SW);
        do_store(c_BASE + 32'h06, 32'hFFFFFFFF, c_F3_SW);
        n_cmp++;
        if (bus.busErr !== 1'b1) begin
            n_fail++; $display("FAIL sw_misalign_err: got %b want 1", bus.busErr);
        end
        n_cmp++;
        if (bus.errAddr !== c_BASE + 32'h06) begin
            n_fail++; $display("FAIL sw_misalign_addr: got %h want %h", bus.errAddr, c_BASE + 32'h06);
        end
        do_store(c_BASE + 32'h09, 32'h0000FFFF, c_F3_SH);
        n_cmp++;
        if (bus.errAddr !== c_BASE + 32'h06) begin
            n_fail++; $display("FAIL first_fault_wins: got %h want %h", bus.errAddr, c_BASE + 32'h06);
        end
        do_load(c_BASE + 32'h04, c_F3_LW, d);
        n_cmp++;
        if (d !== 32'hAAAA5555) begin
            n_fail++; $display("FAIL sw_misalign_nowrite: got %h want %h", d, 32'hAAAA5555);
        end
        do_load(c_BASE + 32'h08, c_F3_LW, d);
        n_cmp++;
        if (d !== 32'h00000000) begin
            n_fail++; $display("FAIL sh_misalign_nowrite: got %h want %h", d, 32'h0);
        end
        pulse_clr();
        n_cmp++;
        if (bus.busErr !== 1'b0) begin
            n_fail++; $display("FAIL clr_err: got %b want 0", bus.busErr);
        end
        n_cmp++;
        if (bus.errAddr !== 32'h0) begin
            n_fail++; $display("FAIL clr_addr: got %h want %h", bus.errAddr, 32'h0);
        end
        // Unused strb with busWe is a fault
        do_store(c_BASE + 32'h04, 32'h12345678, 3'b011);
        n_cmp++;
        if (bus.busErr !== 1'b1 || bus.errAddr !== c_BASE + 32'h04) begin
            n_fail++; $display("FAIL bad_strb: got err=%b addr=%h want err=1 addr=%h",
                               bus.busErr, bus.errAddr, c_BASE + 32'h04);
        end
        do_load(c_BASE + 32'h04, c_F3_LW, d);
        n_cmp++;
        if (d !== 32'hAAAA5555) begin
            n_fail++; $display("FAIL bad_strb_nowrite: got %h want %h", d, 32'hAAAA5555);
        end
        // Fault coincident with clear: fault wins, new address captured
        bus.errClr = 1'b1;
        do_store(c_BASE + 32'h0A, 32'h0, c_F3_SW);
        bus.errClr = 1'b0;
        n_cmp++;
        if (bus.busErr !== 1'b1 || bus.errAddr !== c_BASE + 32'h0A) begin
            n_fail++; $display("FAIL clr_fault_same_cycle: got err=%b addr=%h want err=1 addr=%h",
                               bus.busErr, bus.errAddr, c_BASE + 32'h0A);
        end
        pulse_clr();
        // Loads never fault, even misaligned ones
        do_load(c_BASE + 32'h07, c_F3_LW, d);
        n_cmp++;
        if (bus.busErr !== 1'b0 || d !== 32'hAAAA5555) begin
            n_fail++; $display("FAIL misaligned_load: got err=%b data=%h want err=0 data=%h",
                               bus.busErr, d, 32'hAAAA5555);
        end
    endtask

    task automatic test_range();
        logic [31:0] d;
        do_store(c_BASE + 32'h3FC, 32'h0BADCAFE, c_F3_SW);
        do_load(c_BASE + 32'h3FC, c_F3_LW, d);
        n_cmp++;
        if (d !== 32'h0BADCAFE || bus.busErr !== 1'b0) begin
            n_fail++; $display("FAIL last_word: got data=%h err=%b want data=%h err=0",
                               d, bus.busErr, 32'h0BADCAFE);
        end
        do_store(c_BASE + 32'h400, 32'h12345678, c_F3_SW);
        n_cmp++;
        if (bus.busErr !== 1'b1 || bus.errAddr !== c_BASE + 32'h400) begin
            n_fail++; $display("FAIL oor_store: got err=%b addr=%h want err=1 addr=%h",
                               bus.busErr, bus.errAddr, c_BASE + 32'h400);
        end
        do_load(c_BASE + 32'h400, c_F3_LW, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL oor_load: got %h want %h", d, 32'h0);
        end
        // Word 0 must not have been hit by the aliased out-of-range store
        do_load(c_BASE, c_F3_LW, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL oor_no_alias: got %h want %h", d, 32'h0);
        end
        do_load(c_BASE - 32'h4, c_F3_LW, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL below_base_load: got %h want %h", d, 32'h0);
        end
        pulse_clr();
    endtask

    task automatic test_read_during_write();
        do_store(c_BASE + 32'h30, 32'h12345678, c_F3_SW);
        bus.busAddr  = c_BASE + 32'h30;
        bus.busWData = 32'h00000055;
        bus.strb     = c_F3_SW;
        bus.busWe    = 1'b1;
        @(posedge clk);
        #1;
        bus.busWe    = 1'b0;
        n_cmp++;
        if (bus.busRData !== 32'h12345678) begin
            n_fail++; $display("FAIL rdw_old: got %h want %h", bus.busRData, 32'h12345678);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.busRData !== 32'h00000055) begin
            n_fail++; $display("FAIL rdw_new: got %h want %h", bus.busRData, 32'h00000055);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        do_store(c_BASE + 32'h40, 32'hCAFEF00D, c_F3_SW);
        do_store(c_BASE + 32'h44, 32'h00000000, c_F3_SW);
        do_store(c_BASE + 32'h44, 32'h0, 3'b111);  // set busErr to see it clear
        do_load(c_BASE + 32'h40, c_F3_LW, d);
        // Store in flight while reset rises between edges
        bus.busAddr  = c_BASE + 32'h40;
        bus.busWData = 32'hFFFFFFFF;
        bus.strb     = c_F3_SW;
        bus.busWe    = 1'b1;
        reset        = 1'b1;
        #2;
        n_cmp++;
        if (bus.busRData !== 32'h0 || bus.busErr !== 1'b0 || bus.errAddr !== 32'h0) begin
            n_fail++; $display("FAIL async_reset: got rdata=%h err=%b addr=%h want all 0",
                               bus.busRData, bus.busErr, bus.errAddr);
        end
        @(posedge clk);
        #1;
        bus.busWe = 1'b0;
        reset     = 1'b0;
        do_load(c_BASE + 32'h40, c_F3_LW, d);
        n_cmp++;
        if (d !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL mem_retained: got %h want %h", d, 32'hCAFEF00D);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_faults();
        test_range();
        test_read_during_write();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_data_mem_responder
`default_nettype wire
